// File: rtl/inst_fetch_if.sv
// Fetch-side bundle: instruction memory request/response, execute redirect,
// and the instruction handshake toward decode.
interface inst_fetch_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        id_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ack, imem_rdata, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_rdata, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// RISC-V instruction fetch: single-outstanding imem requests, a small {pc, inst}
// queue toward decode, and redirect handling that drops in-flight responses.
module inst_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          QDEPTH   = 2
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);
  localparam int          PW   = $clog2(QDEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(QDEPTH);
  localparam logic [PW:0] ONE  = (PW+1)'(1);
  localparam logic [31:0] NOP  = 32'h00000013;

  typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_t;

  state_t        state, state_n;
  logic          req, req_n;
  logic [63:0]   addr, addr_n;
  logic [63:0]   fetch_pc, fetch_pc_n;
  logic [63:0]   pend_pc, pend_pc_n;
  logic [PW:0]   count, count_n;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [63:0]   q_pc   [QDEPTH];
  logic [31:0]   q_inst [QDEPTH];
  logic          push, pop, flush, ack, head_valid;
  logic [63:0]   rpc;
  logic [PW:0]   post_pop, post_push_pop;

  assign rpc           = {bus.redirect_pc[63:2], 2'b00};
  assign ack           = req & bus.imem_ack;
  assign head_valid    = (count != '0);
  assign pop           = head_valid & bus.id_ready & ~flush;
  assign post_pop      = count - (head_valid & bus.id_ready ? ONE : '0);
  assign post_push_pop = post_pop + ONE;

  // Next-state: redirect dominates push/pop; a request is never withdrawn before its ack.
  always_comb begin
    state_n    = state;
    req_n      = req;
    addr_n     = addr;
    fetch_pc_n = fetch_pc;
    pend_pc_n  = pend_pc;
    push       = 1'b0;
    flush      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.redirect) begin
          flush   = 1'b1;
          req_n   = 1'b1;
          addr_n  = rpc;
          state_n = BUSY;
        end else if (post_pop < FULL) begin
          req_n   = 1'b1;
          addr_n  = fetch_pc;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (bus.redirect) begin
          flush = 1'b1;
          if (ack) begin
            addr_n = rpc;
          end else begin
            pend_pc_n = rpc;
            state_n   = DISCARD;
          end
        end else if (ack) begin
          push       = 1'b1;
          fetch_pc_n = addr + 64'd4;
          if (post_push_pop < FULL) begin
            addr_n = addr + 64'd4;
          end else begin
            req_n   = 1'b0;
            state_n = IDLE;
          end
        end
      end
      DISCARD: begin
        flush = bus.redirect;
        if (ack) begin
          addr_n  = bus.redirect ? rpc : pend_pc;
          state_n = BUSY;
        end else if (bus.redirect) begin
          pend_pc_n = rpc;
        end
      end
      default: begin
        req_n   = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    if (flush) count_n = '0;
    else       count_n = count + (push ? ONE : '0) - (pop ? ONE : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req      <= 1'b0;
      addr     <= RESET_PC;
      fetch_pc <= RESET_PC;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state    <= state_n;
      req      <= req_n;
      addr     <= addr_n;
      fetch_pc <= fetch_pc_n;
      count    <= count_n;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Queue storage and pending pc carry no reset; occupancy gates their visibility.
  always_ff @(posedge clk) begin
    pend_pc <= pend_pc_n;
    if (push) begin
      q_pc[wr_ptr]   <= addr;
      q_inst[wr_ptr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = addr;
  assign bus.inst_valid = head_valid;
  assign bus.inst       = head_valid ? q_inst[rd_ptr] : NOP;
  assign bus.inst_pc    = head_valid ? q_pc[rd_ptr]   : 64'h0;
endmodule

// File: tb/tb_inst_fetch.sv
// Randomized and directed bench for inst_fetch against a queue-based reference
// model and a variable-latency instruction memory.
module tb_inst_fetch;
  localparam logic [63:0] RPC = 64'h1000;
  localparam int          QD  = 2;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_if bif ();

  inst_fetch #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  bit          m_req, m_drop;
  logic [63:0] m_addr, m_fetch, m_pend;
  int          n_chk = 0;
  int          n_pass = 0;
  int          wait_cnt, lat, lat_min, lat_max;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0000;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_req   = 1'b0;
    m_drop  = 1'b0;
    m_addr  = RPC;
    m_fetch = RPC;
    m_pend  = 64'h0;
  endtask

  task automatic mem_reset();
    wait_cnt = 0;
    lat      = $urandom_range(lat_min, lat_max);
  endtask

  // One clock of fetch behaviour described in terms of "outstanding" and "drop" flags.
  task automatic model_step(input bit ack, input bit rd, input logic [63:0] rp, input bit rdy);
    logic [63:0] rpm;
    bit          pop;
    rpm = rp & ~64'h3;
    pop = (mq.size() != 0) && rdy;
    if (!m_req) begin
      if (rd) begin
        mq.delete();
        m_req  = 1'b1;
        m_addr = rpm;
      end else begin
        if (pop) void'(mq.pop_front());
        if (mq.size() < QD) begin
          m_req  = 1'b1;
          m_addr = m_fetch;
        end
      end
    end else if (!m_drop) begin
      if (rd) begin
        mq.delete();
        if (ack) m_addr = rpm;
        else begin
          m_drop = 1'b1;
          m_pend = rpm;
        end
      end else begin
        if (pop) void'(mq.pop_front());
        if (ack) begin
          mq.push_back('{m_addr, mem_word(m_addr)});
          m_fetch = m_addr + 64'd4;
          if (mq.size() < QD) m_addr = m_fetch;
          else m_req = 1'b0;
        end
      end
    end else begin
      if (ack) begin
        m_addr = rd ? rpm : m_pend;
        m_drop = 1'b0;
      end else if (rd) begin
        m_pend = rpm;
      end
    end
  endtask

  task automatic compare_all();
    check("imem_req",   64'(bif.imem_req),   64'(m_req));
    check("imem_addr",  bif.imem_addr,       m_addr);
    check("inst_valid", 64'(bif.inst_valid), 64'(mq.size() != 0));
    check("inst",       64'(bif.inst),       64'((mq.size() != 0) ? mq[0].ins : NOP));
    check("inst_pc",    bif.inst_pc,         (mq.size() != 0) ? mq[0].pc : 64'h0);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input bit rd, input logic [63:0] rp, input bit rdy);
    bit req_s, ack_s;
    compare_all();
    req_s = bif.imem_req;
    if (req_s) ack_s = (wait_cnt >= lat);
    else       ack_s = ($urandom_range(0, 3) == 0);
    bif.imem_ack    = ack_s;
    bif.imem_rdata  = mem_word(bif.imem_addr);
    bif.redirect    = rd;
    bif.redirect_pc = rp;
    bif.id_ready    = rdy;
    model_step(ack_s & m_req, rd, rp, rdy);
    @(posedge clk);
    if (req_s) begin
      if (ack_s) begin
        wait_cnt = 0;
        lat      = $urandom_range(lat_min, lat_max);
      end else begin
        wait_cnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   64'(bif.imem_req),   64'h0);
    check({tag, "_addr"},  bif.imem_addr,       RPC);
    check({tag, "_valid"}, 64'(bif.inst_valid), 64'h0);
    check({tag, "_inst"},  64'(bif.inst),       64'(NOP));
    check({tag, "_pc"},    bif.inst_pc,         64'h0);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bif.imem_ack = 1'b0;
    bif.redirect = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    mem_reset();
  endtask

  task automatic rand_cycles(input int n, input int p_rdy, input int p_rd);
    logic [63:0] rp;
    for (int i = 0; i < n; i++) begin
      rp = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF9 : {$urandom, $urandom};
      cycle($urandom_range(0, 99) < p_rd, rp, $urandom_range(0, 99) < p_rdy);
    end
  endtask

  initial begin
    bit found;
    bif.imem_ack    = 1'b0;
    bif.imem_rdata  = 32'h0;
    bif.redirect    = 1'b0;
    bif.redirect_pc = 64'h0;
    bif.id_ready    = 1'b0;
    lat_min = 0;
    lat_max = 0;
    model_reset();
    mem_reset();
    @(negedge clk);

    // Straight-line fetch, zero-wait memory.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 64'h0, 1'b1);
    check("line_addr",  bif.imem_addr,       64'h1008);
    check("line_pc",    bif.inst_pc,         64'h1004);
    check("line_valid", 64'(bif.inst_valid), 64'h1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 64'h0, 1'b1);
    check("line_addr2", bif.imem_addr,       64'h1028);

    // Backpressure fills the queue, then drains.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b0, 64'h0, 1'b0);
    check("bp_req",  64'(bif.imem_req), 64'h0);
    check("bp_pc",   bif.inst_pc,       64'h1000);
    check("bp_inst", 64'(bif.inst),     64'(mem_word(64'h1000)));
    cycle(1'b0, 64'h0, 1'b1);
    check("bp_rereq",  64'(bif.imem_req), 64'h1);
    check("bp_readdr", bif.imem_addr,     64'h1008);
    check("bp_pc2",    bif.inst_pc,       64'h1004);
    for (int i = 0; i < 6; i++) cycle(1'b0, 64'h0, 1'b1);

    // Redirect during a slow request.
    lat_min = 3;
    lat_max = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bif.imem_req && bif.imem_addr == 64'h1004) found = 1'b1;
      else cycle(1'b0, 64'h0, 1'b1);
    end
    check("slow_found_req", 64'(found), 64'h1);
    cycle(1'b0, 64'h0, 1'b1);
    cycle(1'b1, 64'h2002, 1'b1);
    for (int i = 0; i < 20 && bif.imem_addr == 64'h1004; i++) cycle(1'b0, 64'h0, 1'b1);
    check("slow_new_addr", bif.imem_addr, 64'h2000);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bif.inst_valid) found = 1'b1;
      else cycle(1'b0, 64'h0, 1'b1);
    end
    check("slow_valid", 64'(found),   64'h1);
    check("slow_pc",    bif.inst_pc,  64'h2000);

    // Redirect coincident with ack and pop.
    lat_min = 0;
    lat_max = 0;
    do_reset();
    cycle(1'b0, 64'h0, 1'b0);
    cycle(1'b0, 64'h0, 1'b0);
    check("coin_pre_valid", 64'(bif.inst_valid), 64'h1);
    cycle(1'b1, 64'h3000, 1'b1);
    check("coin_valid", 64'(bif.inst_valid), 64'h0);
    check("coin_addr",  bif.imem_addr,       64'h3000);
    check("coin_req",   64'(bif.imem_req),   64'h1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 64'h0, 1'b1);

    // Double redirect while discarding.
    lat_min = 4;
    lat_max = 4;
    do_reset();
    cycle(1'b0, 64'h0, 1'b1);
    cycle(1'b1, 64'h4000, 1'b1);
    cycle(1'b1, 64'h5000, 1'b1);
    for (int i = 0; i < 20 && bif.imem_addr == 64'h1000; i++) cycle(1'b0, 64'h0, 1'b1);
    check("dbl_addr", bif.imem_addr, 64'h5000);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bif.inst_valid) found = 1'b1;
      else cycle(1'b0, 64'h0, 1'b1);
    end
    check("dbl_valid", 64'(found),  64'h1);
    check("dbl_pc",    bif.inst_pc, 64'h5000);

    // Random traffic, then an asynchronous reset between edges.
    lat_min = 0;
    lat_max = 3;
    do_reset();
    rand_cycles(1500, 70, 5);
    @(posedge clk);
    #2 rst = 1'b1;
    bif.imem_ack = 1'b0;
    #1;
    check_reset_outputs("async");
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    mem_reset();
    cycle(1'b0, 64'h0, 1'b1);
    check("restart_req",  64'(bif.imem_req), 64'h1);
    check("restart_addr", bif.imem_addr,     RPC);
    rand_cycles(1500, 60, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
